sonar_ranger: RTL and testbench
===============================

# sonar_ranger

Memory-mapped ultrasonic ranging peripheral that sits between the processor's IO pins and its data path. On command (or free-running), it drives the sensor trigger pin and times the returned echo pulse in microseconds. It latches the result for the processor to read, flagging timeouts and unread-result overruns. It replaces ad-hoc pin toggling through clock dividers with a self-timed measurement engine.

## Interface
- `CYCLES_PER_US`, default 50: clock cycles per microsecond tick (50 MHz clock).
- `TRIG_US`, default 10: trigger pulse width in µs.
- `TIMEOUT_US`, default 30000: maximum wait for echo rise, and maximum echo width, in µs.
- `HOLDOFF_US`, default 60000: dead time after each measurement before the next may start, in µs.
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-low; all state is cleared while it is low.
- `start` in 1: one-cycle processor write strobe that requests a measurement.
- `continuous` in 1: level input; when 1, a new measurement begins automatically whenever the block is idle.
- `echo_in` in 1: raw, asynchronous sensor echo pin.
- `rd_ack` in 1: one-cycle processor read strobe; clears `valid` and `overrun`.
- `trig_out` out 1: sensor trigger pin.
- `distance_us` out 32: last echo width in µs; reads 32'hFFFFFFFF on timeout.
- `valid` out 1: an unread result is present.
- `timeout` out 1: the last result was a timeout.
- `overrun` out 1: a result was overwritten before it was read.
- `busy` out 1: the state machine is not in IDLE.

## Operation
- `echo_in` passes through a 2-flop synchronizer, then a registered edge detector. Rise and fall events are 1-cycle pulses on the synchronized signal.
- A µs prescaler counts 0..`CYCLES_PER_US`-1. It restarts at 0 on every state entry, and it produces a tick when it wraps.
- The state machine has five states:
  - **IDLE:** `busy`=0. Goes to TRIG if `start`=1 or `continuous`=1.
  - **TRIG:** `trig_out`=1 for exactly `TRIG_US*CYCLES_PER_US` cycles, then goes to WAIT_RISE.
  - **WAIT_RISE:** counts µs ticks.
    - On a rise event, clears the µs counter and goes to MEASURE.
    - If the count reaches `TIMEOUT_US`, posts a timeout result and goes to HOLDOFF.
  - **MEASURE:** counts µs ticks while the echo is high.
    - On a fall event, posts the result `distance_us` = completed µs ticks, with `timeout`=0, and goes to HOLDOFF.
    - If the count reaches `TIMEOUT_US`, posts a timeout result and goes to HOLDOFF.
  - **HOLDOFF:** waits `HOLDOFF_US` ticks, then goes to IDLE.
- Posting a timeout result sets `distance_us`=32'hFFFFFFFF and `timeout`=1.
- Posting any result sets `valid`=1.
- `overrun` is set if a result posts while `valid`=1 and `rd_ack`=0 in that same cycle. When `rd_ack` and a post coincide, the post wins: `valid` stays 1 and `overrun` is unchanged.
- A `start` pulse outside IDLE is ignored. `start` is not queued.
- `rd_ack` with no post in that cycle clears `valid` and `overrun`. `distance_us` and `timeout` hold their values until the next post.
- The µs counter is 32 bits and saturates at `TIMEOUT_US`. It never wraps.

## Timing
- **Reset values:** `trig_out`=0, `distance_us`=0, `valid`=0, `timeout`=0, `overrun`=0, `busy`=0, state IDLE, synchronizer flops 0.
- **Start latency:** `start` is sampled high at edge N. `busy` and `trig_out` go high after edge N+1.
- **Echo latency:** a raw `echo_in` edge produces its edge event 3 clocks later (2 synchronizer stages plus 1 detector stage).
- **Result latency:** the result posts at the clock edge after the fall event, so `valid` rises 4 clocks after the raw echo fall.
- Measured value equals floor(synchronized high time / `CYCLES_PER_US`), ±1 µs quantization.
- **Reset mid-operation:** `trig_out` drops asynchronously and no partial result is posted.
- **Echo already high on entry to WAIT_RISE:** no rise event occurs, so the measurement times out.
- **Echo glitch inside TRIG or HOLDOFF:** ignored.
- **`continuous` deasserted:** the current measurement completes, then the block stays in IDLE.

## Test plan
All scenarios use `CYCLES_PER_US`=4, `TRIG_US`=2, `TIMEOUT_US`=100, `HOLDOFF_US`=10.
- **Single shot:** pulse `start`, raise `echo_in` 20 cycles after `trig_out` falls, hold it high 200 cycles -> `trig_out` high exactly 8 cycles; `distance_us`=50; `valid`=1 four clocks after the fall; `timeout`=0.
- **No echo:** pulse `start`, keep `echo_in` low -> after 100 µs (400 cycles) in WAIT_RISE, `distance_us`=32'hFFFFFFFF, `timeout`=1, `valid`=1.
- **Overlong echo:** hold `echo_in` high 1000 cycles -> timeout result at 100 µs; later fall events are ignored.
- **Continuous overrun:** `continuous`=1, 40-cycle echoes, never assert `rd_ack` -> second result sets `overrun`=1, `distance_us`=10. Then pulse `rd_ack` -> `valid`=0, `overrun`=0.
- **Busy start:** pulse `start` during MEASURE -> no extra trigger; exactly one result posts.
- **Async reset:** drive `reset` low during TRIG -> `trig_out`=0 immediately; after release, all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/sonar_ranger.sv
// rtl/sonar_ranger.sv - ultrasonic ranging engine: trigger pulse, echo timing, result latch
module sonar_ranger #(
    parameter int CYCLES_PER_US = 50,
    parameter int TRIG_US       = 10,
    parameter int TIMEOUT_US    = 30000,
    parameter int HOLDOFF_US    = 60000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        echo_in,
    input  logic        rd_ack,
    output logic        trig_out,
    output logic [31:0] distance_us,
    output logic        valid,
    output logic        timeout,
    output logic        overrun,
    output logic        busy
);

    localparam int              PW       = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(CYCLES_PER_US - 1);
    localparam logic [31:0]     TRIG_LEN = 32'(TRIG_US);
    localparam logic [31:0]     TMO_LEN  = 32'(TIMEOUT_US);
    localparam logic [31:0]     HOLD_LEN = 32'(HOLDOFF_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t        state;
    logic          echo_s1;
    logic          echo_s2;
    logic          echo_d;
    logic          rise_evt;
    logic          fall_evt;
    logic [PW-1:0] presc;
    logic [31:0]   us_cnt;
    logic [31:0]   us_inc;
    logic          tick;
    logic          post_en;
    logic          post_tmo;

    assign tick   = (presc == PRE_LAST);
    assign us_inc = tick ? us_cnt + 32'd1 : us_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1  <= 1'b0;
            echo_s2  <= 1'b0;
            echo_d   <= 1'b0;
            rise_evt <= 1'b0;
            fall_evt <= 1'b0;
        end else begin
            echo_s1  <= echo_in;
            echo_s2  <= echo_s1;
            echo_d   <= echo_s2;
            rise_evt <= echo_s2 & ~echo_d;
            fall_evt <= ~echo_s2 & echo_d;
        end
    end

    // A tick landing on the same edge as the fall still counts as a completed microsecond.
    always_comb begin
        post_en  = 1'b0;
        post_tmo = 1'b0;
        if (state == WAIT_RISE && !rise_evt && us_inc >= TMO_LEN) begin
            post_en  = 1'b1;
            post_tmo = 1'b1;
        end
        if (state == MEASURE) begin
            if (fall_evt) begin
                post_en = 1'b1;
            end else if (us_inc >= TMO_LEN) begin
                post_en  = 1'b1;
                post_tmo = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            presc       <= '0;
            us_cnt      <= '0;
            trig_out    <= 1'b0;
            busy        <= 1'b0;
            distance_us <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            busy     <= (state != IDLE);
            trig_out <= (state == TRIG);
            presc    <= tick ? '0 : presc + 1'b1;
            us_cnt   <= us_inc;

            if (rd_ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    presc  <= '0;
                    us_cnt <= '0;
                    if (start || continuous) begin
                        state <= TRIG;
                    end
                end
                TRIG: begin
                    if (tick && us_inc == TRIG_LEN) begin
                        state  <= WAIT_RISE;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (rise_evt) begin
                        state  <= MEASURE;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                MEASURE: begin
                end
                HOLDOFF: begin
                    if (tick && us_inc == HOLD_LEN) begin
                        state  <= IDLE;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A post overrides a coincident rd_ack: valid stays set and overrun is left alone.
            if (post_en) begin
                distance_us <= post_tmo ? 32'hFFFF_FFFF : us_inc;
                timeout     <= post_tmo;
                valid       <= 1'b1;
                overrun     <= overrun | (valid & ~rd_ack);
                state       <= HOLDOFF;
                presc       <= '0;
                us_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sonar_ranger.sv
// tb/tb_sonar_ranger.sv - scoreboard bench for sonar_ranger with randomized echo responder
module tb_sonar_ranger;

    localparam int CPU  = 4;
    localparam int TRG  = 2;
    localparam int TMO  = 100;
    localparam int HOLD = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        echo_in = 1'b0;
    logic        rd_ack = 1'b0;
    logic        trig_out;
    logic [31:0] distance_us;
    logic        valid;
    logic        timeout;
    logic        overrun;
    logic        busy;

    sonar_ranger #(
        .CYCLES_PER_US(CPU),
        .TRIG_US(TRG),
        .TIMEOUT_US(TMO),
        .HOLDOFF_US(HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .continuous(continuous),
        .echo_in(echo_in),
        .rd_ack(rd_ack),
        .trig_out(trig_out),
        .distance_us(distance_us),
        .valid(valid),
        .timeout(timeout),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_d[$];
    logic        exp_t[$];
    int          resp_mode = 4;
    int          fix_d = 0;
    int          fix_h = 0;
    bit          lat_chk = 0;
    bit          auto_ack = 1;
    bit          resp_active = 0;
    int          ack_reqs = 0;
    int          ack_done = 0;
    int          trig_count = 0;
    int          tw = 0;
    bit          hit_rst = 0;
    logic        prev_trig = 1'b0;
    logic        pv = 1'b0;
    logic        po = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int cyc);
        n_vec++;
        n_err++;
        $display("FAIL %s: condition not reached within %0d cycles", name, cyc);
    endtask

    // Reference: echo of h raw cycles reads floor(h / CPU) us unless that reaches the timeout.
    task automatic model_push(input int h);
        if (h / CPU >= TMO) begin
            exp_d.push_back(32'hFFFF_FFFF);
            exp_t.push_back(1'b1);
        end else begin
            exp_d.push_back(32'(h / CPU));
            exp_t.push_back(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, 32'(trig_out), 32'd0);
        check({tag, "_dist"}, distance_us, 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 10 && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (!busy && !resp_active && !echo_in) quiet++;
            else quiet = 0;
        end
        if (quiet < 10) fail_now(name, cyc);
    endtask

    // Trigger width and trigger count
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) hit_rst = 1;
            if (trig_out) begin
                if (tw == 0) trig_count++;
                tw++;
            end else begin
                if (tw != 0 && !hit_rst) check("trig_width", 32'(tw), 32'(TRG * CPU));
                tw = 0;
                hit_rst = 0;
            end
        end
    end

    // Scoreboard monitor: a post shows as valid rising or, when already valid, overrun rising
    initial begin
        forever begin
            @(negedge clock);
            if (reset && ((valid && !pv) || (overrun && !po))) begin
                if (exp_d.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_post: got distance %h, none expected", distance_us);
                end else begin
                    check("distance", distance_us, exp_d.pop_front());
                    check("timeout_flag", 32'(timeout), 32'(exp_t.pop_front()));
                end
            end
            pv = valid;
            po = overrun;
        end
    end

    // Processor read side
    initial begin
        forever begin
            @(negedge clock);
            if (reset && ((auto_ack && valid) || ack_done != ack_reqs)) begin
                ack_done = ack_reqs;
                rd_ack = 1'b1;
                @(negedge clock);
                rd_ack = 1'b0;
            end
        end
    end

    // Sensor model: answers each trigger falling edge according to resp_mode
    initial begin
        int d;
        int h;
        forever begin
            @(negedge clock);
            if (prev_trig && !trig_out && reset && resp_mode != 4) begin
                resp_active = 1;
                if (resp_mode == 1) begin
                    exp_d.push_back(32'hFFFF_FFFF);
                    exp_t.push_back(1'b1);
                    if (lat_chk) begin
                        repeat (TMO * CPU - 2) @(negedge clock);
                        check("noecho_valid_early", 32'(valid), 32'd0);
                        @(negedge clock);
                        check("noecho_valid_at_timeout", 32'(valid), 32'd1);
                    end
                end else begin
                    case (resp_mode)
                        0: begin
                            d = int'($urandom_range(0, 300));
                            h = int'($urandom_range(2, 380));
                        end
                        2: begin
                            d = int'($urandom_range(0, 50));
                            h = 1000;
                        end
                        default: begin
                            d = fix_d;
                            h = fix_h;
                        end
                    endcase
                    repeat (d) @(negedge clock);
                    echo_in = 1'b1;
                    model_push(h);
                    repeat (h) @(negedge clock);
                    echo_in = 1'b0;
                    if (lat_chk && h < TMO * CPU) begin
                        repeat (3) @(negedge clock);
                        check("valid_before_fall_plus4", 32'(valid), 32'd0);
                        @(negedge clock);
                        check("valid_at_fall_plus4", 32'(valid), 32'd1);
                    end
                    if (resp_mode == 0 && $urandom_range(0, 1) == 1) begin
                        repeat (6) @(negedge clock);
                        echo_in = 1'b1;
                        repeat (3) @(negedge clock);
                        echo_in = 1'b0;
                    end
                end
                resp_active = 0;
            end
            prev_trig = trig_out;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int tc;
        int cyc;

        repeat (3) @(negedge clock);
        check_all_zero("in_reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        resp_mode = 3;
        fix_d = 20;
        fix_h = 200;
        lat_chk = 1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_lat_busy_n", 32'(busy), 32'd0);
        check("start_lat_trig_n", 32'(trig_out), 32'd0);
        @(negedge clock);
        check("start_lat_busy_n1", 32'(busy), 32'd1);
        check("start_lat_trig_n1", 32'(trig_out), 32'd1);
        wait_idle("single_shot");
        check("single_distance", distance_us, 32'd50);
        check("single_timeout", 32'(timeout), 32'd0);

        resp_mode = 1;
        pulse_start();
        wait_idle("no_echo");
        check("noecho_distance", distance_us, 32'hFFFF_FFFF);
        check("noecho_timeout", 32'(timeout), 32'd1);

        resp_mode = 2;
        lat_chk = 0;
        pulse_start();
        wait_idle("overlong");
        check("overlong_distance", distance_us, 32'hFFFF_FFFF);
        check("overlong_timeout", 32'(timeout), 32'd1);

        resp_mode = 0;
        lat_chk = 1;
        repeat (8) begin
            pulse_start();
            wait_idle("random_shot");
        end

        resp_mode = 3;
        fix_d = 10;
        fix_h = 200;
        tc = trig_count;
        pulse_start();
        cyc = 0;
        while (!echo_in && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        if (!echo_in) fail_now("busy_start_echo", cyc);
        repeat (20) @(negedge clock);
        pulse_start();
        wait_idle("busy_start");
        check("busy_start_triggers", 32'(trig_count - tc), 32'd1);
        check("busy_start_pending", 32'(exp_d.size()), 32'd0);

        auto_ack = 0;
        lat_chk = 0;
        fix_d = 5;
        fix_h = 40;
        @(negedge clock);
        continuous = 1'b1;
        cyc = 0;
        while (!overrun && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        continuous = 1'b0;
        if (!overrun) fail_now("cont_overrun", cyc);
        check("cont_overrun_flag", 32'(overrun), 32'd1);
        check("cont_valid", 32'(valid), 32'd1);
        check("cont_distance", distance_us, 32'd10);
        wait_idle("continuous");
        ack_reqs++;
        repeat (3) @(negedge clock);
        check("ack_valid_clear", 32'(valid), 32'd0);
        check("ack_overrun_clear", 32'(overrun), 32'd0);
        check("ack_distance_hold", distance_us, 32'd10);
        auto_ack = 1;

        resp_mode = 4;
        pulse_start();
        cyc = 0;
        while (!trig_out && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        if (!trig_out) fail_now("reset_trig_seen", cyc);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_trig_drop", 32'(trig_out), 32'd0);
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_all_zero("after_reset");
        repeat (100) @(negedge clock);
        check("after_reset_busy", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_d.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
